alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational 4-bit ALU (a, b, s -> f) between two requesters.
//  Each requester presents an operand pair and a select code with a valid/ready handshake.
//  The block grants round-robin, holds the ALU inputs stable, captures f and returns it.
//  Sits between the lab's control logic (switch/FSM requesters) and the shared alu instance.
// PARAMETERS
//  W           4  operand/result width (a, b, f)
//  SW          3  select width (s)
//  EXEC_CYCLES 1  cycles alu_* are held before alu_f is sampled (1..15)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous, active-high reset
//  req0_valid  in   1   ch0 request present
//  req0_ready  out  1   ch0 request accepted this cycle
//  req0_a      in   W   ch0 operand a
//  req0_b      in   W   ch0 operand b
//  req0_s      in   SW  ch0 select
//  rsp0_valid  out  1   ch0 result pulse
//  rsp0_f      out  W   ch0 result
//  req1_*/rsp1_*        same as ch0 for channel 1
//  alu_a       out  W   to shared ALU a
//  alu_b       out  W   to shared ALU b
//  alu_s       out  SW  to shared ALU s
//  alu_f       in   W   from shared ALU f
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, cnt=0, rr pointer favours ch0.
//  - FSM IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: reqN_ready is combinational, high only for the granted channel.
//    Grant = the only valid channel; if both are valid, the channel named by the rr pointer.
//    On valid&ready: latch a, b, s into the alu_* registers; cnt=0; go to EXEC.
//  - EXEC: alu_* are stable; cnt increments each cycle.
//    At cnt==EXEC_CYCLES-1: sample alu_f into rspN_f of the granted channel; go to RESP.
//  - RESP: rspN_valid=1 for exactly one cycle (no backpressure).
//    rr pointer moves to the other channel; go to IDLE.
//  - Latency: accept at edge T -> rsp_valid high in cycle T+EXEC_CYCLES+1.
//    Throughput: one op per EXEC_CYCLES+2 cycles.
//  - reqN_ready=0 in EXEC and RESP; a requester holds valid/operands until ready.
//    Valid dropped before ready: nothing is accepted.
//  - rspN_f holds its value until that channel's next response.
//    alu_* hold the last operation's values while idle.
//  - rst asserted mid-operation: the operation is discarded, no rsp pulse.
//    Next cycle is IDLE with the ch0-priority pointer.
//  - Width: alu_f is sampled as W bits unmodified; no carry/overflow handled here.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined:
//    ch0 always wins simultaneous requests; the rr pointer is removed.
//    ch1 is served only when ch0_valid=0.
//  ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING  (bench ALU model: f = (a + b) mod 16, s ignored; EXEC_CYCLES=1)
//  1. rst high 2 cycles, all req low -> every output 0, busy=0.
//  2. ch0 only: a=1010, b=0011, s=000 -> ready0 same cycle; rsp0_valid 2 cycles after accept.
//     rsp0_f=1101; alu_s=000 during EXEC.
//  3. Both valid from reset: ch0 a=0001 b=0001, ch1 a=0111 b=0001.
//     ch0 served first (rsp0_f=0010), then ch1 (rsp1_f=1000); ch1 waits 3 cycles for ready.
//  4. Both held valid for 6 ops -> grants alternate 0,1,0,1,0,1.
//     With ALU_ARB_FIXED_PRIO_EN: 0,0,0,0,0,0 and ch1 never granted.
//  5. rst pulsed in EXEC of a ch1 op (a=1111, b=0001) -> no rsp1_valid; rsp1_f stays 0.
//     Next simultaneous request is granted to ch0.
//  6. EXEC_CYCLES=4, ch1 a=1000 b=1000 -> rsp1_valid 5 cycles after accept, rsp1_f=0000.
//     busy=1 for exactly 5 cycles.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN to give ch0 fixed priority instead of round-robin.
module alu_rr_arbiter #(
    parameter int W           = 4,
    parameter int SW          = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [SW-1:0] req0_s,
    output logic          rsp0_valid,
    output logic [W-1:0]  rsp0_f,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [SW-1:0] req1_s,
    output logic          rsp1_valid,
    output logic [W-1:0]  rsp1_f,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [SW-1:0] alu_s,
    input  logic [W-1:0]  alu_f,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       gnt_ch;
    logic       sel_ch;
    logic       accept;
    logic       exec_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign sel_ch = ~req0_valid;
`else
    logic rr_ptr;

    // rr_ptr only matters on a tie; a lone requester always wins
    always_comb begin
        sel_ch = ~req0_valid;
        if (req0_valid && req1_valid)
            sel_ch = rr_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (state == RESP)
            rr_ptr <= ~gnt_ch;
    end
`endif

    // ready is gated by rst so nothing can be accepted while reset is asserted
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !sel_ch;
    assign req1_ready = (state == IDLE) && !rst && req1_valid &&  sel_ch;
    assign accept     = req0_ready || req1_ready;
    assign exec_done  = (state == EXEC) && (cnt == CNT_LAST);

    assign busy       = (state != IDLE);
    assign rsp0_valid = (state == RESP) && !gnt_ch;
    assign rsp1_valid = (state == RESP) &&  gnt_ch;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (exec_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            gnt_ch <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_s  <= '0;
            rsp0_f <= '0;
            rsp1_f <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt_ch <= sel_ch;
                cnt    <= '0;
                alu_a  <= sel_ch ? req1_a : req0_a;
                alu_b  <= sel_ch ? req1_b : req0_b;
                alu_s  <= sel_ch ? req1_s : req0_s;
            end else if (state == EXEC) begin
                cnt <= cnt + 4'd1;
            end
            // result register of the served channel only; the other keeps its last value
            if (exec_done) begin
                if (gnt_ch)
                    rsp1_f <= alu_f;
                else
                    rsp0_f <= alu_f;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with an (a + b) mod 16 ALU model.
module tb_alu_rr_arbiter;

    localparam int W  = 4;
    localparam int SW = 3;
    localparam int EC = 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic          req0_valid = 0, req1_valid = 0;
    logic [W-1:0]  req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [SW-1:0] req0_s = 0, req1_s = 0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [W-1:0]  rsp0_f, rsp1_f, alu_a, alu_b, alu_f;
    logic [SW-1:0] alu_s;

    logic          e4_req0_valid = 0, e4_req1_valid = 0;
    logic [W-1:0]  e4_req1_a = 0, e4_req1_b = 0;
    logic          e4_req0_ready, e4_req1_ready, e4_rsp0_valid, e4_rsp1_valid, e4_busy;
    logic [W-1:0]  e4_rsp0_f, e4_rsp1_f, e4_alu_a, e4_alu_b, e4_alu_f;
    logic [SW-1:0] e4_alu_s;

    assign alu_f    = alu_a + alu_b;
    assign e4_alu_f = e4_alu_a + e4_alu_b;

    alu_rr_arbiter #(.W(W), .SW(SW), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
        .rsp0_valid(rsp0_valid), .rsp0_f(rsp0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
        .rsp1_valid(rsp1_valid), .rsp1_f(rsp1_f),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(alu_f), .busy(busy)
    );

    alu_rr_arbiter #(.W(W), .SW(SW), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(e4_req0_valid), .req0_ready(e4_req0_ready), .req0_a(4'd0), .req0_b(4'd0), .req0_s(3'd0),
        .rsp0_valid(e4_rsp0_valid), .rsp0_f(e4_rsp0_f),
        .req1_valid(e4_req1_valid), .req1_ready(e4_req1_ready), .req1_a(e4_req1_a), .req1_b(e4_req1_b), .req1_s(3'd5),
        .rsp1_valid(e4_rsp1_valid), .rsp1_f(e4_rsp1_f),
        .alu_a(e4_alu_a), .alu_b(e4_alu_b), .alu_s(e4_alu_s), .alu_f(e4_alu_f), .busy(e4_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; e4_req0_valid = 0; e4_req1_valid = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req0_a = 4'($urandom); req0_b = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        n_tests++;
        if ({rsp0_f, rsp1_f, alu_a, alu_b, alu_s} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {rsp0_f, rsp1_f, alu_a, alu_b, alu_s});
        end
        n_tests++;
        if ({e4_busy, e4_rsp1_valid, e4_rsp1_f, e4_alu_a} !== '0) begin
            n_fail++; $display("FAIL reset_e4: got %h expected 0", {e4_busy, e4_rsp1_valid, e4_rsp1_f, e4_alu_a});
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_release: got %b expected 00000", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
    endtask

    task automatic test_single_ch0();
        reset_dut();
        req0_valid = 1; req0_a = 4'b1010; req0_b = 4'b0011; req0_s = 3'b000;
        req1_valid = 0; req1_a = 4'($urandom); req1_b = 4'($urandom);
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0; req0_a = 4'($urandom);
        #1;
        n_tests++;
        if ({alu_a, alu_b, alu_s, busy, rsp0_valid} !== {4'b1010, 4'b0011, 3'b000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_exec: got %h expected %h", {alu_a, alu_b, alu_s, busy, rsp0_valid}, {4'b1010, 4'b0011, 3'b000, 1'b1, 1'b0});
        end
        @(negedge clk); #1;
        n_tests++;
        if ({rsp0_valid, rsp1_valid, rsp0_f} !== {2'b10, 4'b1101}) begin
            n_fail++; $display("FAIL single_rsp: got %b expected 101101", {rsp0_valid, rsp1_valid, rsp0_f});
        end
        @(negedge clk); #1;
        n_tests++;
        if ({rsp0_valid, busy, rsp0_f, alu_a} !== {2'b00, 4'b1101, 4'b1010}) begin
            n_fail++; $display("FAIL single_hold: got %b expected 0011011010", {rsp0_valid, busy, rsp0_f, alu_a});
        end
    endtask

    task automatic test_both_from_reset();
        int waited;
        logic [W-1:0] got0;
        bit seen0;
        reset_dut();
        req0_valid = 1; req0_a = 4'b0001; req0_b = 4'b0001; req0_s = 3'd2;
        req1_valid = 1; req1_a = 4'b0111; req1_b = 4'b0001; req1_s = 3'd3;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL both_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        waited = 0; seen0 = 0; got0 = 'x;
        while (req1_ready !== 1'b1 && waited < 10) begin
            waited++;
            @(negedge clk);
            req0_valid = 0;
            #1;
            if (rsp0_valid === 1'b1) begin seen0 = 1; got0 = rsp0_f; end
        end
        n_tests++;
        if (waited != 3) begin
            n_fail++; $display("FAIL both_ch1_wait: got %0d cycles expected 3", waited);
        end
        n_tests++;
        if (!seen0 || got0 !== 4'b0010) begin
            n_fail++; $display("FAIL both_rsp0: got seen=%0d f=%b expected seen=1 f=0010", seen0, got0);
        end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk); #1;
        n_tests++;
        if ({rsp1_valid, rsp0_valid, rsp1_f} !== {2'b10, 4'b1000}) begin
            n_fail++; $display("FAIL both_rsp1: got %b expected 101000", {rsp1_valid, rsp0_valid, rsp1_f});
        end
    endtask

    // Model: tie goes to the channel not served last (ch0 after reset), or ch0 with fixed priority.
    task automatic test_stream(input int n_ops, input bit force_both);
        bit            v[2];
        logic [W-1:0]  a[2], b[2];
        logic [SW-1:0] s[2];
        int            lst, g, ops, guard, n_ch1;
        logic [W-1:0]  exp_f;
        logic [1:0]    exp_v;
        reset_dut();
        v[0] = 0; v[1] = 0; lst = 1; ops = 0; guard = 0; n_ch1 = 0;
        while (ops < n_ops && guard < 2000) begin
            guard++;
            for (int c = 0; c < 2; c++)
                if (!v[c]) begin
                    a[c] = 4'($urandom); b[c] = 4'($urandom); s[c] = 3'($urandom);
                    v[c] = force_both ? 1'b1 : ($urandom_range(0, 2) == 0);
                end
            req0_valid = v[0]; req0_a = a[0]; req0_b = b[0]; req0_s = s[0];
            req1_valid = v[1]; req1_a = a[1]; req1_b = b[1]; req1_s = s[1];
            #1;
            if (!v[0] && !v[1]) begin
                n_tests++;
                if ({req0_ready, req1_ready, busy} !== 3'b000) begin
                    n_fail++; $display("FAIL stream_idle: got %b expected 000", {req0_ready, req1_ready, busy});
                end
                @(negedge clk);
                continue;
            end
            g = (v[0] && v[1]) ? (FIXED ? 0 : 1 - lst) : (v[1] ? 1 : 0);
            exp_v = (g == 1) ? 2'b10 : 2'b01;
            n_tests++;
            if ({req1_ready, req0_ready} !== exp_v) begin
                n_fail++; $display("FAIL stream_grant op%0d: got ready10=%b expected %b", ops, {req1_ready, req0_ready}, exp_v);
            end
            exp_f = 4'(a[g] + b[g]);
            if (g == 1) n_ch1++;
            lst = g; ops++;
            for (int k = 1; k <= EC + 1; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    n_tests++;
                    if ({alu_a, alu_b, alu_s} !== {a[g], b[g], s[g]}) begin
                        n_fail++; $display("FAIL stream_alu op%0d: got %h expected %h", ops, {alu_a, alu_b, alu_s}, {a[g], b[g], s[g]});
                    end
                    v[g] = 0;
                    if (force_both || $urandom_range(0, 1) == 1) begin
                        a[g] = 4'($urandom); b[g] = 4'($urandom); s[g] = 3'($urandom); v[g] = 1;
                    end
                    req0_valid = v[0]; req0_a = a[0]; req0_b = b[0]; req0_s = s[0];
                    req1_valid = v[1]; req1_a = a[1]; req1_b = b[1]; req1_s = s[1];
                end
                #1;
                n_tests++;
                if ({busy, req0_ready, req1_ready, rsp1_valid, rsp0_valid} !== {3'b100, (k == EC + 1) ? exp_v : 2'b00}) begin
                    n_fail++; $display("FAIL stream_busy op%0d k%0d: got %b expected %b", ops, k,
                        {busy, req0_ready, req1_ready, rsp1_valid, rsp0_valid}, {3'b100, (k == EC + 1) ? exp_v : 2'b00});
                end
                if (k == EC + 1) begin
                    n_tests++;
                    if (((g == 1) ? rsp1_f : rsp0_f) !== exp_f) begin
                        n_fail++; $display("FAIL stream_f op%0d ch%0d: got %h expected %h", ops, g, (g == 1) ? rsp1_f : rsp0_f, exp_f);
                    end
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (ops != n_ops) begin
            n_fail++; $display("FAIL stream_timeout: got %0d ops expected %0d", ops, n_ops);
        end
        if (force_both) begin
            n_tests++;
            if (n_ch1 != (FIXED ? 0 : n_ops / 2)) begin
                n_fail++; $display("FAIL stream_ch1_count: got %0d expected %0d", n_ch1, FIXED ? 0 : n_ops / 2);
            end
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_rst_mid_op();
        reset_dut();
        req0_valid = 0;
        req1_valid = 1; req1_a = 4'b1111; req1_b = 4'b0001; req1_s = 3'd1;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rstmid_grant: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk);
        rst = 1; req1_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        n_tests++;
        if ({busy, rsp1_valid, rsp1_f} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_discard: got %b expected 000000", {busy, rsp1_valid, rsp1_f});
        end
        @(negedge clk); #1;
        n_tests++;
        if ({rsp1_valid, rsp1_f} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_no_rsp: got %b expected 00000", {rsp1_valid, rsp1_f});
        end
        req0_valid = 1; req0_a = 4'($urandom); req0_b = 4'($urandom);
        req1_valid = 1;
        #1;
        n_tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_ptr: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exec4();
        logic [W-1:0] ta[2], tb[2], tf[2];
        int nbusy, rsp_k;
        logic [W-1:0] got_f;
        ta[0] = 4'b0011; tb[0] = 4'b0100; tf[0] = 4'b0111;
        ta[1] = 4'b1000; tb[1] = 4'b1000; tf[1] = 4'b0000;
        reset_dut();
        for (int op = 0; op < 2; op++) begin
            e4_req1_valid = 1; e4_req1_a = ta[op]; e4_req1_b = tb[op];
            #1;
            n_tests++;
            if ({e4_req0_ready, e4_req1_ready} !== 2'b01) begin
                n_fail++; $display("FAIL e4_grant op%0d: got %b expected 01", op, {e4_req0_ready, e4_req1_ready});
            end
            nbusy = 0; rsp_k = -1; got_f = 'x;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                e4_req1_valid = 0;
                #1;
                if (e4_busy === 1'b1) nbusy++;
                if (e4_rsp1_valid === 1'b1) begin
                    if (rsp_k < 0) rsp_k = k; else rsp_k = 99;
                    got_f = e4_rsp1_f;
                end
            end
            n_tests++;
            if (rsp_k != 5) begin
                n_fail++; $display("FAIL e4_latency op%0d: got %0d expected 5", op, rsp_k);
            end
            n_tests++;
            if (nbusy != 5) begin
                n_fail++; $display("FAIL e4_busy op%0d: got %0d expected 5", op, nbusy);
            end
            n_tests++;
            if (got_f !== tf[op]) begin
                n_fail++; $display("FAIL e4_f op%0d: got %b expected %b", op, got_f, tf[op]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_ch0();
        test_both_from_reset();
        test_stream(6, 1'b1);
        test_stream(40, 1'b0);
        test_rst_mid_op();
        test_exec4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
